mod_n_updown_counter: RTL and testbench
=======================================

// Module: mod_n_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter: successor of the 2-bit enable counter.
//  - Counts only while x=1 and holds while x=0.
//  - Raises Mealy terminal-count output z on the cycle the count wraps.
//  - Adds direction select, synchronous parallel load, a configurable modulus and a sticky overflow flag.
//  - Used as a cascadable stage: z of stage k drives x of stage k+1.
// PARAMETERS
//  WIDTH    2  counter width in bits; WIDTH >= 1
//  MODULUS  4  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk      in   1      clock, rising-edge active
//  rst_n    in   1      reset, asynchronous assert, active-low
//  x        in   1      count enable
//  up       in   1      direction: 1 = increment, 0 = decrement
//  load     in   1      synchronous parallel load strobe
//  d        in   WIDTH  load value
//  clr_ovf  in   1      synchronous clear of ovf
//  q        out  WIDTH  current count (registered)
//  z        out  1      terminal-count, combinational (Mealy)
//  ovf      out  1      sticky wrap flag (registered)
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst_n); it forces q=0 and ovf=0 immediately.
//  - No output has a combinational path from rst_n except through q.
//  - TERM = MODULUS-1 when up=1; TERM = 0 when up=0.
//  - z = x & ~load & (q == TERM). z is valid in the same cycle as its inputs and has no register delay.
//  - Per rising clk edge, in priority order:
//    1. load=1: q <= (d > MODULUS-1) ? MODULUS-1 : d. Out-of-range load clamps. x is ignored. z=0.
//    2. x=1, up=1: q <= (q == MODULUS-1) ? 0 : q+1.
//    3. x=1, up=0: q <= (q == 0) ? MODULUS-1 : q-1.
//    4. x=0: q holds.
//  - ovf:
//    - Set on any edge where z=1.
//    - Cleared on an edge where clr_ovf=1 and z=0.
//    - Set wins when set and clear occur on the same edge. Otherwise ovf holds.
//  - Direction change mid-count takes effect on the same edge. There is no turnaround cycle.
//  - Arithmetic is done at WIDTH+1 bits internally. q never holds a value >= MODULUS.
//  - MODULUS == 2**WIDTH is natural wrap and needs no compare-reset special case in behaviour.
//  - rst_n asserted mid-count: q=0 and ovf=0 asynchronously. The first edge after rst_n deasserts applies the normal rules from q=0.
//  - Parameter check: an out-of-range MODULUS is a fatal elaboration error (generate-time $error).
// CONFIGURATION
//  Macro COUNTER_SATURATE_EN:
//  - Defined:
//    - Up-count at MODULUS-1 holds MODULUS-1. Down-count at 0 holds 0.
//    - z keeps its formula, so it stays 1 each cycle x is held at the terminal value, and ovf is set.
//    - Load and reset are unchanged.
//  - Undefined: wrap-around behaviour as above. This is the default build.
// TESTING
//  1. Reset/hold: rst_n=0 with clk running -> q=0, ovf=0. Release with x=0 for 5 cycles -> q stays 0, z=0.
//  2. Default params, x=1, up=1 for 5 edges -> q = 1,2,3,0,1. z=1 only while q=3. ovf=1 after the 4th edge.
//  3. WIDTH=4, MODULUS=10, up=0, x=1 from q=0 -> z=1 at q=0. Next q=9, then 8.
//     Then load=1, d=12 -> q=9 (clamp), z=0 that cycle.
//  4. Simultaneous events: q=3, x=1, up=1, clr_ovf=1 -> after the edge q=0, ovf=1 (set wins).
//     Next edge with clr_ovf=1, x=0 -> ovf=0.
//  5. Async reset mid-run: assert rst_n low between edges at q=2 -> q=0 before the next edge, with no clk edge needed.
//  6. COUNTER_SATURATE_EN build, default params: x=1, up=1 for 6 edges -> q = 1,2,3,3,3,3. z=1 for every cycle at q=3.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter
// Modulo-MODULUS up/down counter with count enable, synchronous parallel
// load (clamped to the count range), Mealy terminal-count output z and a
// sticky wrap flag ovf. Stages cascade by wiring z of one stage to x of the
// next.
//
// Build option: define COUNTER_SATURATE_EN to make the counter stop at the
// terminal value instead of wrapping. z and ovf keep their meaning; load and
// reset are unaffected. The default build (macro undefined) wraps.
module mod_n_updown_counter #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             z,
  output logic             ovf
);

  // Reject a modulus outside 2..2**WIDTH at elaboration time.
  generate
    if ((WIDTH < 1) || (MODULUS < 2) ||
        (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_param
      $error("mod_n_updown_counter: MODULUS=%0d out of range for WIDTH=%0d",
             MODULUS, WIDTH);
    end
  endgenerate

  // Highest legal count, held one bit wider than q so that MODULUS-1 and the
  // increment of it are both representable when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0] LP_TOP = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] LP_ONE = (WIDTH+1)'(1);

  // Narrow a WIDTH+1 bit value onto the count range; anything above the top
  // of the range becomes the top, which is also how an oversized load clamps.
  function automatic logic [WIDTH-1:0] clamp_to_range(input logic [WIDTH:0] v);
    logic [WIDTH:0] c;
    c = (v > LP_TOP) ? LP_TOP : v;
    return c[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_term;
  logic [WIDTH:0]   w_next;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_z;

  assign w_q_ext   = {1'b0, r_q};
  assign w_d_ext   = {1'b0, d};
  assign w_inc     = w_q_ext + LP_ONE;
  assign w_dec     = w_q_ext - LP_ONE;
  assign w_at_top  = (w_q_ext == LP_TOP);
  assign w_at_zero = (w_q_ext == '0);

  // Terminal value depends on direction; z is combinational from x, up,
  // load and the registered count, so a cascade sees it in the same cycle.
  always_comb begin
    w_term = up ? LP_TOP : '0;
    w_z    = x & ~load & (w_q_ext == w_term);
  end

  // Next count: load beats counting, direction applies on the same edge.
  always_comb begin
    w_next = w_q_ext;
    if (load) begin
      w_next = w_d_ext;
    end else if (x) begin
      if (up) begin
`ifdef COUNTER_SATURATE_EN
        w_next = w_at_top ? LP_TOP : w_inc;
`else
        w_next = w_at_top ? '0 : w_inc;
`endif
      end else begin
`ifdef COUNTER_SATURATE_EN
        w_next = w_at_zero ? '0 : w_dec;
`else
        w_next = w_at_zero ? LP_TOP : w_dec;
`endif
      end
    end
  end

  // Count register; asynchronous reset returns to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= clamp_to_range(w_next);
    end
  end

  // Sticky wrap flag: a terminal-count event wins over a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_z) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign q   = r_q;
  assign z   = w_z;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Testbench for mod_n_updown_counter.
// Two instances share clk/rst_n: dut0 uses default parameters (natural wrap,
// MODULUS == 2**WIDTH) and dut1 uses WIDTH=4, MODULUS=10. Stimulus drives
// inputs just after each rising edge and queues the outputs expected for that
// cycle; a monitor on the falling edge pops and compares them.
// Expected values follow COUNTER_SATURATE_EN when it is defined.
module tb_mod_n_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       x0, up0, load0, clr0;
  logic [1:0] d0;
  logic [1:0] q0;
  logic       z0, ovf0;
  logic       x1, up1, load1, clr1;
  logic [3:0] d1;
  logic [3:0] q1;
  logic       z1, ovf1;

  int n_tests;
  int n_fail;

  typedef struct {
    int    dut;
    string name;
    int    q;
    bit    z;
    bit    ovf;
  } exp_t;

  exp_t sb[$];

`ifdef COUNTER_SATURATE_EN
  localparam int T2_N    = 7;
  int t2_q [T2_N] = '{0, 1, 2, 3, 3, 3, 3};
  bit t2_z [T2_N] = '{0, 0, 0, 1, 1, 1, 1};
  bit t2_o [T2_N] = '{0, 0, 0, 0, 1, 1, 1};
  localparam int T2_HOLD = 3;
  localparam int T4_Q    = 3;
  localparam int T3_Q1   = 0;
  localparam bit T3_Z1   = 1'b1;
  localparam int T3_Q2   = 0;
  localparam int T3_Q3   = 9;
`else
  localparam int T2_N    = 6;
  int t2_q [T2_N] = '{0, 1, 2, 3, 0, 1};
  bit t2_z [T2_N] = '{0, 0, 0, 1, 0, 0};
  bit t2_o [T2_N] = '{0, 0, 0, 0, 1, 1};
  localparam int T2_HOLD = 2;
  localparam int T4_Q    = 0;
  localparam int T3_Q1   = 9;
  localparam bit T3_Z1   = 1'b0;
  localparam int T3_Q2   = 8;
  localparam int T3_Q3   = 0;
`endif

  mod_n_updown_counter dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x0),
    .up     (up0),
    .load   (load0),
    .d      (d0),
    .clr_ovf(clr0),
    .q      (q0),
    .z      (z0),
    .ovf    (ovf0)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x1),
    .up     (up1),
    .load   (load1),
    .d      (d1),
    .clr_ovf(clr1),
    .q      (q1),
    .z      (z1),
    .ovf    (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp0(string n, int q, bit z, bit o);
    exp_t e;
    e.dut = 0; e.name = n; e.q = q; e.z = z; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic exp1(string n, int q, bit z, bit o);
    exp_t e;
    e.dut = 1; e.name = n; e.q = q; e.z = z; e.ovf = o;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   aq;
      bit   az, ao;
      e = sb.pop_front();
      if (e.dut == 0) begin
        aq = int'(q0); az = z0; ao = ovf0;
      end else begin
        aq = int'(q1); az = z1; ao = ovf1;
      end
      n_tests++;
      if (aq != e.q) begin
        n_fail++;
        $display("FAIL %s.q dut%0d: got %0d, required %0d", e.name, e.dut, aq, e.q);
      end
      n_tests++;
      if (az != e.z) begin
        n_fail++;
        $display("FAIL %s.z dut%0d: got %0d, required %0d", e.name, e.dut, az, e.z);
      end
      n_tests++;
      if (ao != e.ovf) begin
        n_fail++;
        $display("FAIL %s.ovf dut%0d: got %0d, required %0d", e.name, e.dut, ao, e.ovf);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    x0 = 0; up0 = 0; load0 = 0; clr0 = 0; d0 = '0;
    x1 = 0; up1 = 0; load1 = 0; clr1 = 0; d1 = '0;

    // Reset and hold
    repeat (2) cyc();
    exp0("rst", 0, 0, 0);
    exp1("rst", 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    exp0("rel", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp0("hold", 0, 0, 0);
    end

    // Up-count with wrap (or saturation)
    x0 = 1; up0 = 1;
    for (int k = 0; k < T2_N; k++) begin
      if (k > 0) cyc();
      exp0($sformatf("up%0d", k), t2_q[k], t2_z[k], t2_o[k]);
    end
    cyc();
    x0 = 0;
    exp0("up_stop", T2_HOLD, 0, 1);

    // Load with clear, then terminal count coinciding with clear
    cyc();
    load0 = 1; d0 = 2'd2; clr0 = 1;
    exp0("ld2_clr", T2_HOLD, 0, 1);
    cyc();
    load0 = 0; clr0 = 0; x0 = 1; up0 = 1;
    exp0("after_clr", 2, 0, 0);
    cyc();
    clr0 = 1;
    exp0("term_clr", 3, 1, 0);
    cyc();
    x0 = 0;
    exp0("set_wins", T4_Q, 0, 1);
    cyc();
    clr0 = 0;
    exp0("cleared", T4_Q, 0, 0);

    // Build up ovf, then asynchronous reset between edges
    cyc();
    load0 = 1; d0 = 2'd3;
    exp0("ld3", T4_Q, 0, 0);
    cyc();
    load0 = 0; x0 = 1; up0 = 1;
    exp0("at3", 3, 1, 0);
    cyc();
    x0 = 0; load0 = 1; d0 = 2'd2;
    exp0("ld2b", T4_Q, 0, 1);
    cyc();
    load0 = 0;
    exp0("q2", 2, 0, 1);
    cyc();
    rst_n = 1'b0;
    exp0("async_rst", 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    exp0("post_rst", 0, 0, 0);
    cyc();
    x0 = 1; up0 = 1;
    exp0("restart", 0, 0, 0);
    cyc();
    x0 = 0;
    exp0("restart1", 1, 0, 0);

    // WIDTH=4 MODULUS=10: down-count through 0, clamped load
    cyc();
    x1 = 1; up1 = 0;
    exp1("dn0", 0, 1, 0);
    cyc();
    exp1("dn1", T3_Q1, T3_Z1, 1);
    cyc();
    load1 = 1; d1 = 4'd12;
    exp1("ld12", T3_Q2, 0, 1);
    cyc();
    load1 = 0; x1 = 0;
    exp1("clamp9", 9, 0, 1);
    cyc();
    x1 = 1; up1 = 1;
    exp1("up_at9", 9, 1, 1);
    cyc();
    x1 = 0; clr1 = 1;
    exp1("wrap9", T3_Q3, 0, 1);
    cyc();
    clr1 = 0; load1 = 1; d1 = 4'd5;
    exp1("ld5", T3_Q3, 0, 0);
    cyc();
    load1 = 0; x1 = 1; up1 = 0;
    exp1("q5", 5, 0, 0);
    cyc();
    up1 = 1;
    exp1("q4", 4, 0, 0);
    cyc();
    up1 = 0;
    exp1("turn_up", 5, 0, 0);
    cyc();
    x1 = 0;
    exp1("turn_dn", 4, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
